// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-file target.
// Contents: FSM state enum, ACK/NACK bit levels, DEVID constant, 3-input majority helper.
// Optional build macro I2C_GLITCH_FILTER_EN is consumed by i2c_line_cond.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    WDATA,
    RDATA,
    MACK,
    IGNORE
  } i2c_state_e;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic [7:0] DEVID    = 8'hE5;

  // Majority of three samples, used by the optional line glitch filter.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA line conditioning: 2-FF synchronizers, optional 3-sample majority
// filter (build macro I2C_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
// Ports:
//   clk, reset (async, active-low)
//   scl_in, sda_in     raw pin levels
//   sda_o              conditioned SDA level
//   scl_rise_o/fall_o  one-clk SCL edge pulses
//   start_o/stop_o     one-clk START/STOP pulses
module i2c_line_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_s;
  logic       sda_s;
  logic       scl_q;
  logic       sda_q;

  // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q;
  logic [1:0] sda_hist_q;
  logic       scl_flt_q;
  logic       sda_flt_q;

  // Majority over the last three synchronized samples rejects single-clk spikes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_flt_q  <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_flt_q  <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_s = scl_flt_q;
  assign sda_s = sda_flt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  // Edge/condition flags are registered alongside the line levels they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      scl_rise_o <= scl_s & ~scl_q;
      scl_fall_o <= ~scl_s & scl_q;
      start_o    <= scl_s & scl_q & sda_q & ~sda_s;
      stop_o     <= scl_s & scl_q & ~sda_q & sda_s;
    end
  end

  assign sda_o = sda_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an internal 2**REG_AW byte register file (ADXL345-style, addr 0x53).
// Register 0 reads as DEVID; I2C writes to it are ACKed and dropped.
// Optional build macro I2C_GLITCH_FILTER_EN enables the line majority filter.
// Ports:
//   clk, reset (async, active-low)
//   scl_in, sda_in    raw bus levels;  sda_oe  1 = pull SDA low
//   host_we/addr/wdata host write port;  host_rdata  combinational read
//   wr_strobe/addr/data  notification of each committed I2C write
//   busy              addressed transfer in progress
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h53,
  parameter int unsigned REG_AW   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned NREG      = 1 << REG_AW;
  localparam logic [3:0]  BITS_DONE = 4'd8;
  localparam logic [3:0]  ACK_SLOT  = 4'd9;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_cond u_line_cond (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  logic [7:0]        regs_q [NREG];
  i2c_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [REG_AW-1:0] ptr_q, ptr_d, ptr_inc_c;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        rd_cur_c, rd_nxt_c;

  assign ptr_inc_c  = ptr_q + REG_AW'(1);
  assign rd_cur_c   = (ptr_q == '0) ? DEVID : regs_q[ptr_q];
  assign rd_nxt_c   = (ptr_inc_c == '0) ? DEVID : regs_q[ptr_inc_c];
  assign host_rdata = (host_addr == '0) ? DEVID : regs_q[host_addr];

  // Register file: the I2C commit is applied in the wr_strobe cycle and wins over the host.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[REG_AW'(i)] <= 8'h00;
    end else begin
      if (host_we) regs_q[host_addr] <= host_wdata;
      if (wr_strobe_q) regs_q[wr_addr_q] <= wr_data_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sh_q        <= 8'h00;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state logic. cnt counts sampled bits; ACK_SLOT marks the ACK clock.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ADDR;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: sda_oe_d = 1'b0;
        ADDR: begin
          if (scl_rise && cnt_q < BITS_DONE) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BITS_DONE) begin
            cnt_d = 4'd0;
            if (sh_q[7:1] == DEV_ADDR) begin
              rw_d     = sh_q[0];
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          // The first SCL fall after entry ends the ACK clock.
          if (scl_fall) begin
            if (rw_q) begin
              sh_d     = rd_cur_c;
              sda_oe_d = ~rd_cur_c[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = REG;
            end
          end
        end
        REG, WDATA: begin
          if (scl_rise && cnt_q < BITS_DONE) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == BITS_DONE) begin
            sda_oe_d = 1'b1;
            cnt_d    = ACK_SLOT;
            if (state_q == REG) begin
              ptr_d = sh_q[REG_AW-1:0];
            end else begin
              ptr_d = ptr_inc_c;
              if (ptr_q != '0) begin
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = sh_q;
              end
            end
          end else if (scl_fall && cnt_q == ACK_SLOT) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = WDATA;
          end
        end
        RDATA: begin
          // Each fall presents the next bit; the fall after bit 8 hands SDA to the master.
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == BITS_DONE) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = MACK;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) cnt_d = ACK_SLOT;
            else state_d = IGNORE;
          end else if (scl_fall && cnt_q == ACK_SLOT) begin
            ptr_d    = ptr_inc_c;
            sh_d     = rd_nxt_c;
            sda_oe_d = ~rd_nxt_c[7];
            cnt_d    = 4'd0;
            state_d  = RDATA;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bus-level master tasks, a behavioural
// register/pointer model, a per-cycle monitor for write notifications and SDA
// stability while SCL is high, and randomized transactions.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int NR = 64;
  localparam int Q  = 8;  // quarter SCL period in clks

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl_in, sda_in, sda_oe;
  logic       host_we_drv, host_we, coll_en;
  logic [5:0] host_addr, wr_addr;
  logic [7:0] host_wdata, host_rdata, wr_data;
  logic       wr_strobe, busy;

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;
  assign host_we = host_we_drv | (coll_en & wr_strobe);

  i2c_target_regs dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mregs [NR];
  int          mptr = 0;
  logic [13:0] expq [$];
  logic [7:0]  rdq [$];

  function automatic logic [7:0] mread(input int a);
    return (a == 0) ? 8'hE5 : mregs[a];
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every I2C write notification must match the model's next expected write,
  // and SDA drive must never change while SCL is held high.
  logic prev_oe = 1'b0, prev_scl = 1'b0;
  always @(posedge clk) begin
    #2;
    if (reset) begin
      if (wr_strobe) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL wr_strobe_unexpected got=%0h/%0h exp=none", wr_addr, wr_data);
        end else begin
          logic [13:0] e;
          e = expq.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            errors++;
            $display("FAIL wr_notify got=%0h/%0h exp=%0h/%0h", wr_addr, wr_data, e[13:8], e[7:0]);
          end
        end
      end
      if (scl_m && prev_scl) begin
        checks++;
        if (sda_oe !== prev_oe) begin
          errors++;
          $display("FAIL sda_oe_stable_scl_high got=%0b exp=%0b", sda_oe, prev_oe);
        end
      end
    end
    prev_oe  = sda_oe;
    prev_scl = scl_m;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0; wq(Q);
    end
    sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); acked = ~sda_in; wq(Q); scl_m = 1'b0; wq(Q);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wq(Q); scl_m = 1'b1; wq(Q); b = {b[6:0], sda_in}; wq(Q); scl_m = 1'b0;
    end
    wq(Q); sda_m = nack; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0; wq(Q); sda_m = 1'b1;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk); host_addr = a; host_wdata = d; host_we_drv = 1'b1;
    @(posedge clk); #1; host_we_drv = 1'b0; mregs[a] = d;
  endtask

  task automatic host_peek(input logic [5:0] a, input logic [7:0] exp);
    @(negedge clk); host_addr = a;
    @(posedge clk); #1; chk("host_rdata_lit", host_rdata, exp);
  endtask

  // Random host traffic with every read compared against the model.
  task automatic host_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      @(negedge clk);
      host_addr = 6'($urandom_range(0, NR-1)); host_wdata = 8'($urandom); host_we_drv = we;
      @(posedge clk); #1;
      host_we_drv = 1'b0;
      if (we) mregs[host_addr] = host_wdata;
      chk("host_rdata_model", host_rdata, mread(int'(host_addr)));
    end
  endtask

  task automatic wr_tx(input logic [7:0] rb, input logic [31:0] d, input int n);
    logic a;
    logic [7:0] v;
    i2c_start();
    send_byte(8'hA6, a); chk("wr_addr_ack", a, 1); chk("busy_set", busy, 1);
    send_byte(rb, a); chk("wr_reg_ack", a, 1);
    mptr = int'(rb) % NR;
    for (int i = 0; i < n; i++) begin
      v = d[31-8*i -: 8];
      if (mptr != 0) begin
        expq.push_back({6'(mptr), v});
        mregs[mptr] = v;
      end
      send_byte(v, a); chk("wr_data_ack", a, 1);
      mptr = (mptr + 1) % NR;
    end
    i2c_stop(); chk("busy_clr", busy, 0);
  endtask

  task automatic rd_tx(input logic set_ptr, input logic [7:0] rb, input int n);
    logic a;
    logic [7:0] b;
    if (set_ptr) begin
      i2c_start();
      send_byte(8'hA6, a); chk("rd_addr_w_ack", a, 1);
      send_byte(rb, a); chk("rd_reg_ack", a, 1);
      mptr = int'(rb) % NR;
    end
    i2c_start();
    send_byte(8'hA7, a); chk("rd_addr_r_ack", a, 1); chk("busy_set_rd", busy, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n-1, b);
      rdq.push_back(b);
      chk("rd_byte_model", b, mread(mptr));
      if (i < n-1) mptr = (mptr + 1) % NR;
    end
    chk("rd_sda_released", sda_oe, 0);
    i2c_stop(); chk("busy_clr_rd", busy, 0);
  endtask

  task automatic other_tx(input logic [7:0] ab);
    logic a;
    i2c_start();
    send_byte(ab, a); chk("other_addr_no_ack", a, 0); chk("other_busy", busy, 0);
    i2c_stop();
  endtask

  logic [7:0] abyte;
  logic       ack_b;

  initial begin
    reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    host_we_drv = 1'b0; host_addr = '0; host_wdata = '0; coll_en = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    wq(4);
    chk("rst_sda_oe", sda_oe, 0); chk("rst_busy", busy, 0); chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0); chk("rst_wr_data", wr_data, 0);
    reset = 1'b1;
    wq(4);
    host_peek(6'h00, 8'hE5);
    host_peek(6'h2D, 8'h00);

    // Single register write.
    wr_tx(8'h2D, 32'h08000000, 1);
    host_peek(6'h2D, 8'h08);

    // Burst read with repeated START after host preload.
    for (int i = 0; i < 6; i++) host_write(6'(8'h32 + i), 8'(8'h11 * (i + 1)));
    rdq.delete();
    rd_tx(1'b1, 8'h32, 6);
    for (int i = 0; i < 6; i++) chk("burst_rd_lit", rdq[i], 8'h11 * (i + 1));

    // Non-matching address.
    other_tx(8'h3A);

    // Pointer wrap on write and read; register 0 stays DEVID.
    wr_tx(8'h3F, 32'hAABB0000, 2);
    host_peek(6'h3F, 8'hAA);
    host_peek(6'h00, 8'hE5);
    rdq.delete();
    rd_tx(1'b1, 8'h00, 1);
    chk("devid_rd_lit", rdq[0], 8'hE5);
    rdq.delete();
    rd_tx(1'b1, 8'h3F, 2);
    chk("wrap_rd0_lit", rdq[0], 8'hAA);
    chk("wrap_rd1_lit", rdq[1], 8'hE5);

    // Same-clk host/I2C write collision: I2C data must win.
    @(negedge clk); host_addr = 6'h10; host_wdata = 8'h77; coll_en = 1'b1;
    wr_tx(8'h10, 32'h99000000, 1);
    coll_en = 1'b0;
    host_peek(6'h10, 8'h99);

    // Reset during the address ACK low phase.
    abyte = 8'hA6;
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      sda_m = abyte[i]; wq(Q); scl_m = 1'b1; wq(2*Q); scl_m = 1'b0; wq(Q);
    end
    sda_m = 1'b1; wq(2);
    chk("ack_drive_pre_reset", sda_oe, 1);
    @(negedge clk); reset = 1'b0; #1;
    chk("oe_async_reset", sda_oe, 0);
    chk("busy_async_reset", busy, 0);
    wq(3); reset = 1'b1;
    for (int i = 0; i < NR; i++) mregs[i] = 8'h00;
    mptr = 0;
    scl_m = 1'b1; wq(Q); scl_m = 1'b0; wq(Q);
    i2c_stop();
    host_peek(6'h2D, 8'h00);
    wr_tx(8'h05, 32'h5A000000, 1);
    host_peek(6'h05, 8'h5A);

`ifdef I2C_GLITCH_FILTER_EN
    // One-clk SDA low spike with SCL high must not be taken as START.
    @(negedge clk); sda_m = 1'b0;
    @(negedge clk); sda_m = 1'b1;
    wq(10);
    chk("glitch_busy", busy, 0);
    scl_m = 1'b0; wq(Q);
    send_byte(8'hA6, ack_b);
    chk("glitch_no_start_ack", ack_b, 0);
    i2c_stop();
`endif

    // Randomized traffic against the model.
    host_phase(40);
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 4))
        0: host_phase(20);
        1: wr_tx(8'($urandom_range(0, 255)), $urandom, $urandom_range(1, 4));
        2: rd_tx(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
        3: rd_tx(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          logic [6:0] a7;
          a7 = 7'($urandom_range(0, 127));
          if (a7 == 7'h53) a7 = 7'h1D;
          other_tx({a7, 1'($urandom_range(0, 1))});
        end
      endcase
    end
    host_phase(30);

    chk("no_pending_writes", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
